// File: rtl/rv32_mem_pkg.sv
// Shared RV32 load/store definitions: funct3 codes, responder FSM states and
// error-cause codes used by the data-memory responder and the lane aligner.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Checked in priority order: funct3 first, then alignment, then range.
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_FUNCT3 = 2'd1;
  localparam logic [1:0] ERR_ALIGN  = 2'd2;
  localparam logic [1:0] ERR_RANGE  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for RV32 loads/stores: byte enables, store data
// replication, misalignment detection and load extract/sign-extension.
module lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic        misalign,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rword[{addr_lo, 3'b000} +: 8];
  assign half_v = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = 32'h0;
    misalign  = 1'b0;
    rdata_ext = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      F3_H, F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
        rdata_ext = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_sh  = wdata;
        misalign  = |addr_lo;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time over valid/ready, committed
// after WAIT_CYCLES. Define DMEM_RESP_PERF_EN to add load/store/error counters.
//
//   state  | meaning
//   S_IDLE | ready for a request; accept latches it
//   S_WAIT | counting WAIT_CYCLES; access commits on the last count
//   S_RESP | response held stable until rsp_ready
module dmem_resp
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_RESP_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;

  logic        lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_funct3;

  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_funct3;

  logic [31:0]      ram [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;

  logic [3:0]  be;
  logic [31:0] wdata_sh, rdata_ext;
  logic        misalign, f3_bad;
  logic [1:0]  cause;
  logic        accept, commit, rsp_hs;

  // With zero wait the access commits on the accept edge, straight from the inputs.
  assign acc_we     = (state == S_IDLE) ? req_we     : lat_we;
  assign acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
  assign acc_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;

  assign idx   = acc_addr[IDX_W+1:2];
  assign rword = ram[idx];

  lsu_align u_align (
    .funct3    (acc_funct3),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .misalign  (misalign),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    f3_bad = 1'b1;
    case (acc_funct3)
      F3_B, F3_H, F3_W: f3_bad = 1'b0;
      F3_BU, F3_HU:     f3_bad = acc_we;
      default:          f3_bad = 1'b1;
    endcase
  end

  always_comb begin
    cause = ERR_NONE;
    if (f3_bad)                         cause = ERR_FUNCT3;
    else if (misalign)                  cause = ERR_ALIGN;
    else if (|acc_addr[31:IDX_W+2])     cause = ERR_RANGE;
  end

  assign accept = (state == S_IDLE) && req_valid;
  assign commit = (accept && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (wait_cnt == CNT_LAST));
  assign rsp_hs = (state == S_RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == CNT_LAST) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_funct3 <= 3'b000;
    end else begin
      if (accept) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
      end
      if (state == S_WAIT) wait_cnt <= (wait_cnt == CNT_LAST) ? '0 : wait_cnt + 1'b1;
      if (commit) begin
        rsp_err   <= (cause != ERR_NONE);
        rsp_rdata <= ((cause != ERR_NONE) || acc_we) ? 32'h0 : rdata_ext;
      end
      if (rsp_hs) begin
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; rst only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc_we && (cause == ERR_NONE)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
      end
    end
  end

`ifdef DMEM_RESP_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= 32'h0;
      perf_stores <= 32'h0;
      perf_errs   <= 32'h0;
    end else if (rsp_hs) begin
      if (rsp_err)     perf_errs   <= perf_errs + 32'd1;
      else if (lat_we) perf_stores <= perf_stores + 32'd1;
      else             perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule
